sat_ctr_bank: RTL
=================

# sat_ctr_bank

Parametrised bank of independent saturating up/down counters for the pipeline's prediction and retry-tracking logic. Each channel is an N-bit counter clamped to a programmable range, with per-channel clear, load, increment and decrement. It adds range-fault detection and optional sticky overflow flags that a single fixed-range counter does not provide. Consumers are the branch predictor tables and cache retry throttles, which read `count`, `at_max` and `at_min` directly.

## Interface
Parameters:
- `N_CH`, 4, number of independent channels (≥1)
- `W`, 3, counter width in bits (2..8)
- `MAX`, 5, upper saturation bound; constraint `MIN < MAX ≤ 2^W-1`
- `MIN`, 0, lower saturation bound
- `RST_VAL`, 0, value after reset or clear; constraint `MIN ≤ RST_VAL ≤ MAX`

Ports:
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  reset, synchronous, active-low
- `inc`  in  N_CH  per-channel increment request
- `dec`  in  N_CH  per-channel decrement request
- `clr`  in  N_CH  per-channel clear to `RST_VAL`
- `ld`  in  N_CH  per-channel load strobe
- `ld_val`  in  N_CH*W  load values; channel i uses bits `[i*W +: W]`
- `count`  out  N_CH*W  registered counter values, same packing as `ld_val`
- `at_max`  out  N_CH  `count == MAX`, decoded from the register
- `at_min`  out  N_CH  `count == MIN`, decoded from the register
- `err`  out  N_CH  one-cycle registered fault pulse
- `ovf`  out  N_CH  sticky overflow flag; present only with `SAT_CTR_OVF_FLAG_EN`

## Operation
Per channel, at each rising edge, the priority order is:
1. `rst`=0: `count`=`RST_VAL`, `err`=0, `ovf`=0, in all channels.
2. `clr`=1: `count`=`RST_VAL`, `err`=0, `ovf`=0.
3. `ld`=1:
   - If `ld_val` is in [`MIN`,`MAX`], `count`=`ld_val` and `err`=0.
   - If `ld_val` > `MAX`, `count`=`MAX` and `err`=1.
   - If `ld_val` < `MIN`, `count`=`MIN` and `err`=1.
4. `inc` and `dec` both 1: hold the count (net zero), `err`=0.
5. `inc`=1 only: `count`+1. At `MAX`, hold at `MAX`. If `SAT_CTR_OVF_FLAG_EN` is defined, also set `ovf`.
6. `dec`=1 only: `count`-1. At `MIN`, hold at `MIN`. No flag.
7. No request: hold.

Additional rules:
- **State fault:** if the register holds a value outside [`MIN`,`MAX`] (SEU or an X-resolved value), the next edge forces `count`=`RST_VAL` and `err`=1. This check overrides steps 3–7 but not `clr` or `rst`.
- **Arithmetic:** performed in W+1 bits, so increment and decrement never wrap; results are clamped before the register write.
- **Channel independence:** channels are fully independent, so simultaneous requests on different channels never interact.
- **Reset values:** `count`=`RST_VAL` and `err`=0 on every channel. `at_min` and `at_max` follow from `RST_VAL`. `ovf`=0.

## Timing
- **Latency:** an operation sampled at edge k is visible on `count`, `at_max` and `at_min` after edge k. The flags are combinational decodes of the register, with no extra cycle.
- **`err`:** asserted for exactly the one cycle after the faulting edge. It clears on the next edge unless a new fault occurs.
- **`ovf`:** once set, stays high until `clr` or reset. A decrement does not clear it.
- **Request strobes:** single-cycle. Holding `inc` high for n cycles yields min(n, `MAX`-`count`) increments.
- **Reset mid-operation:** when `rst` is low, all other inputs are ignored at that edge. When `rst` deasserts, operation resumes on the following edge.

## Configuration
- `SAT_CTR_OVF_FLAG_EN` defined:
  - The `ovf` port and its per-channel sticky registers exist.
  - `ovf` is set by `inc` while at `MAX` (step 5).
- `SAT_CTR_OVF_FLAG_EN` undefined:
  - The port and registers are omitted.
  - Saturation at `MAX` is silent.
  - All other behaviour is identical.

## Structure
- **Shared package `sat_ctr_pkg`:**
  - Operation-select enum: `OP_HOLD`, `OP_CLR`, `OP_LD`, `OP_INC`, `OP_DEC`.
  - Priority-resolve function that maps {clr, ld, inc, dec} to the op.
  - Default parameter constants.
- **Sub-module `sat_ctr_cell`:** one channel, containing the register, clamp logic, fault check and optional `ovf`. The bank instantiates it with a generate loop over `N_CH` and does only port slicing.
- **Elaboration check:** the bank checks the parameter constraints at elaboration with a generate-time error.

## Test plan
All scenarios use the defaults (`N_CH`=4, `W`=3, `MIN`=0, `MAX`=5, `RST_VAL`=0) unless stated.
- **Reset:** `rst`=0 for 2 cycles, then high → all `count`=0, `at_min`=4'b1111, `at_max`=0, `err`=0, `ovf`=0.
- **Saturate up:** ch0 `inc` held 8 cycles → count 1,2,3,4,5,5,5,5. `at_max[0]`=1 from cycle 5. `ovf[0]`=1 after cycle 6 (macro on) and stays 1 after 2 `dec` cycles (count 3).
- **Priority:** ch1 `clr`=1, `ld`=1 with `ld_val`=4, and `inc`=1 in the same cycle → `count[1]`=0. Next cycle, `ld`=1 with `ld_val`=4 → 4. Next, `inc`=1 and `dec`=1 together → stays 4.
- **Load clamp:** ch2 `ld_val`=7 → `count[2]`=5 and `err[2]` high for exactly one cycle. `ld_val`=3 → 3 with `err[2]`=0.
- **Fault and mid-operation reset:** force ch3 register to 6 → next edge `count[3]`=0 and `err[3]`=1. Then `rst`=0 during a 3-cycle `inc` burst on all channels → all counts 0 on the reset edge, and increments resume on the edge after deassertion.

Source files
------------

// File: rtl/sat_ctr_pkg.sv
// Shared definitions for the saturating counter bank.
//   - sat_op_e    : per-channel operation selected for the current edge
//   - resolve_op  : maps the {clr, ld, inc, dec} request strobes to one operation
//   - DEF_*       : default parameter values used by sat_ctr_cell and sat_ctr_bank
package sat_ctr_pkg;

  localparam int DEF_N_CH    = 4;
  localparam int DEF_W       = 3;
  localparam int DEF_MAX     = 5;
  localparam int DEF_MIN     = 0;
  localparam int DEF_RST_VAL = 0;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LD,
    OP_INC,
    OP_DEC
  } sat_op_e;

  // Priority: clr > ld > (inc and dec cancel) > inc > dec > hold.
  function automatic sat_op_e resolve_op(input logic clr, input logic ld,
                                         input logic inc, input logic dec);
    sat_op_e op;
    if (clr)             op = OP_CLR;
    else if (ld)         op = OP_LD;
    else if (inc && dec) op = OP_HOLD;
    else if (inc)        op = OP_INC;
    else if (dec)        op = OP_DEC;
    else                 op = OP_HOLD;
    return op;
  endfunction

endpackage

// File: rtl/sat_ctr_cell.sv
// One channel of the saturating counter bank: count register, range clamp,
// state-fault check, one-cycle error pulse and optional sticky overflow flag.
// Optional feature macro: SAT_CTR_OVF_FLAG_EN (adds the ovf port and register).
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset
//   inc/dec in   increment / decrement request
//   clr     in   clear to RST_VAL
//   ld      in   load strobe, value on ld_val
//   ld_val  in   W-bit load value
//   count   out  registered counter value
//   at_max  out  count == MAX
//   at_min  out  count == MIN
//   err     out  registered one-cycle fault pulse
//   ovf     out  sticky overflow (only with SAT_CTR_OVF_FLAG_EN)
module sat_ctr_cell
  import sat_ctr_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MAX     = DEF_MAX,
  parameter int MIN     = DEF_MIN,
  parameter int RST_VAL = DEF_RST_VAL
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] count,
  output logic         at_max,
  output logic         at_min,
`ifdef SAT_CTR_OVF_FLAG_EN
  output logic         ovf,
`endif
  output logic         err
);

  localparam logic [W-1:0] MaxW = W'(MAX);
  localparam logic [W-1:0] MinW = W'(MIN);
  localparam logic [W-1:0] RstW = W'(RST_VAL);

  logic [W-1:0] r_count;
  logic [W-1:0] w_count_nxt;
  logic         r_err;
  logic         w_err_nxt;
  logic         w_fault;
  logic [W:0]   w_inc_sum;
  logic [W:0]   w_dec_diff;
  sat_op_e      w_op;

`ifdef SAT_CTR_OVF_FLAG_EN
  logic r_ovf;
  logic w_ovf_nxt;
  assign ovf = r_ovf;
`endif

  assign w_op       = resolve_op(clr, ld, inc, dec);
  // Signed int compares so a zero MIN does not produce a constant unsigned test.
  assign w_fault    = (int'(r_count) > MAX) || (int'(r_count) < MIN);
  // One extra bit so neither direction can wrap before the clamp.
  assign w_inc_sum  = {1'b0, r_count} + {{W{1'b0}}, 1'b1};
  assign w_dec_diff = {1'b0, r_count} - {{W{1'b0}}, 1'b1};

  always_comb begin
    w_count_nxt = r_count;
    w_err_nxt   = 1'b0;
`ifdef SAT_CTR_OVF_FLAG_EN
    w_ovf_nxt   = r_ovf;
`endif
    if (w_op == OP_CLR) begin
      w_count_nxt = RstW;
`ifdef SAT_CTR_OVF_FLAG_EN
      w_ovf_nxt   = 1'b0;
`endif
    end else if (w_fault) begin
      // Corrupted state wins over every request except clear.
      w_count_nxt = RstW;
      w_err_nxt   = 1'b1;
    end else begin
      unique case (w_op)
        OP_LD: begin
          if (int'(ld_val) > MAX) begin
            w_count_nxt = MaxW;
            w_err_nxt   = 1'b1;
          end else if (int'(ld_val) < MIN) begin
            w_count_nxt = MinW;
            w_err_nxt   = 1'b1;
          end else begin
            w_count_nxt = ld_val;
          end
        end
        OP_INC: begin
          if (int'(w_inc_sum) > MAX) begin
            w_count_nxt = MaxW;
`ifdef SAT_CTR_OVF_FLAG_EN
            w_ovf_nxt   = 1'b1;
`endif
          end else begin
            w_count_nxt = w_inc_sum[W-1:0];
          end
        end
        OP_DEC: begin
          if ($signed(w_dec_diff) < MIN) w_count_nxt = MinW;
          else                           w_count_nxt = w_dec_diff[W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= RstW;
      r_err   <= 1'b0;
`ifdef SAT_CTR_OVF_FLAG_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
`ifdef SAT_CTR_OVF_FLAG_EN
      r_ovf   <= w_ovf_nxt;
`endif
    end
  end

  assign count  = r_count;
  assign err    = r_err;
  assign at_max = (r_count == MaxW);
  assign at_min = (r_count == MinW);

endmodule

// File: rtl/sat_ctr_bank.sv
// Bank of N_CH independent saturating up/down counters clamped to [MIN, MAX].
// Optional feature macro: SAT_CTR_OVF_FLAG_EN (adds the per-channel sticky ovf port).
// Ports:
//   clk     in   rising-edge clock
//   rst     in   synchronous active-low reset
//   inc     in   [N_CH]    increment requests
//   dec     in   [N_CH]    decrement requests
//   clr     in   [N_CH]    clear to RST_VAL
//   ld      in   [N_CH]    load strobes
//   ld_val  in   [N_CH*W]  load values, channel i at [i*W +: W]
//   count   out  [N_CH*W]  counter values, same packing
//   at_max  out  [N_CH]    count == MAX
//   at_min  out  [N_CH]    count == MIN
//   err     out  [N_CH]    one-cycle fault pulse
//   ovf     out  [N_CH]    sticky overflow (only with SAT_CTR_OVF_FLAG_EN)
module sat_ctr_bank
  import sat_ctr_pkg::*;
#(
  parameter int N_CH    = DEF_N_CH,
  parameter int W       = DEF_W,
  parameter int MAX     = DEF_MAX,
  parameter int MIN     = DEF_MIN,
  parameter int RST_VAL = DEF_RST_VAL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   inc,
  input  logic [N_CH-1:0]   dec,
  input  logic [N_CH-1:0]   clr,
  input  logic [N_CH-1:0]   ld,
  input  logic [N_CH*W-1:0] ld_val,
  output logic [N_CH*W-1:0] count,
  output logic [N_CH-1:0]   at_max,
  output logic [N_CH-1:0]   at_min,
`ifdef SAT_CTR_OVF_FLAG_EN
  output logic [N_CH-1:0]   ovf,
`endif
  output logic [N_CH-1:0]   err
);

  if (N_CH < 1 || W < 2 || W > 8 || MIN < 0 || MIN >= MAX || MAX > (1 << W) - 1 ||
      RST_VAL < MIN || RST_VAL > MAX) begin : g_param_err
    $error("sat_ctr_bank: illegal parameter combination");
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    sat_ctr_cell #(
      .W      (W),
      .MAX    (MAX),
      .MIN    (MIN),
      .RST_VAL(RST_VAL)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .dec   (dec[i]),
      .clr   (clr[i]),
      .ld    (ld[i]),
      .ld_val(ld_val[i*W +: W]),
      .count (count[i*W +: W]),
      .at_max(at_max[i]),
      .at_min(at_min[i]),
`ifdef SAT_CTR_OVF_FLAG_EN
      .ovf   (ovf[i]),
`endif
      .err   (err[i])
    );
  end

endmodule
